// File: rtl/tri_and_gate_tester.sv
// -----------------------------------------------------------------------------
// tri_and_gate_tester
//
// Sequencing controller that exercises three 3-input AND gates. On a start
// request it walks the 3-bit pattern p = 0..7 onto all three gates at once,
// holds each pattern for SETTLE_CYCLES cycles, samples the gate outputs for one
// cycle and compares them against the ideal AND result (Yk = (p == 7)).
// Mismatches are accumulated in a saturating error counter and in sticky
// per-gate fail flags. A pass/done status is reported at the end of the run.
//
// Parameters:
//   SETTLE_CYCLES  cycles each pattern is held before sampling (1..255)
//   ERR_W          width of the saturating error counter
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   single-cycle request to begin a run (ignored while busy)
//   abc_out    out  gate drive {C3,B3,A3,C2,B2,A2,C1,B1,A1} = {p,p,p}
//   y_in       in   gate outputs {Y3,Y2,Y1}
//   busy       out  high while a run is in progress
//   done       out  high once the run has finished; results are held
//   pass       out  valid with done; 1 iff err_count == 0
//   err_count  out  mismatching (pattern, gate) samples, saturating
//   fail_gate  out  sticky per-gate mismatch flags, bit k = gate k+1
//
// Optional feature (macro TRI_AND_TESTER_FIRST_FAIL_EN):
//   first_fail_valid  out  a mismatch has been captured in this run
//   first_fail_pat    out  pattern p of the first mismatching check
//   first_fail_gate   out  lowest failing gate number (1..3) of that check
// -----------------------------------------------------------------------------
module tri_and_gate_tester #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [8:0]       abc_out,
   input  logic [2:0]       y_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [2:0]       fail_gate
`ifdef TRI_AND_TESTER_FIRST_FAIL_EN
   ,
   output logic             first_fail_valid,
   output logic [2:0]       first_fail_pat,
   output logic [1:0]       first_fail_gate
`endif
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSettle = 2'd1,
      StCheck  = 2'd2,
      StDone   = 2'd3
   } state_e;

   localparam logic [7:0]       SettleLast = 8'(SETTLE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ErrMax     = '1;

   state_e           state_q, state_d;
   logic [2:0]       p_q, p_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [2:0]       fail_q, fail_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;

`ifdef TRI_AND_TESTER_FIRST_FAIL_EN
   logic             ff_valid_q, ff_valid_d;
   logic [2:0]       ff_pat_q, ff_pat_d;
   logic [1:0]       ff_gate_q, ff_gate_d;
`endif

   logic             accept;
   logic [2:0]       expected;
   logic [2:0]       mism;
   logic [1:0]       n_mism;
   logic [ERR_W+1:0] err_sum;
   logic [ERR_W-1:0] err_sat;
   logic [1:0]       low_gate;

   // A new run is accepted only from a quiescent state. busy stays high for
   // the first DONE cycle, so a start there is still ignored.
   assign accept = start && !busy_q && ((state_q == StIdle) || (state_q == StDone));

   // Every gate sees the same pattern, so every gate has the same expected value.
   assign expected = {3{p_q == 3'd7}};
   assign mism     = y_in ^ expected;
   assign n_mism   = {1'b0, mism[0]} + {1'b0, mism[1]} + {1'b0, mism[2]};

   // Up to three increments per check; clamp the sum at all-ones.
   assign err_sum  = {2'b00, err_q} + {{ERR_W{1'b0}}, n_mism};
   assign err_sat  = (err_sum > {2'b00, ErrMax}) ? ErrMax : err_sum[ERR_W-1:0];

   assign low_gate = mism[0] ? 2'd1 : (mism[1] ? 2'd2 : 2'd3);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fail_d  = fail_q;
`ifdef TRI_AND_TESTER_FIRST_FAIL_EN
      ff_valid_d = ff_valid_q;
      ff_pat_d   = ff_pat_q;
      ff_gate_d  = ff_gate_q;
`endif

      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               state_d = StSettle;
               p_d     = 3'd0;
               cnt_d   = 8'd0;
               err_d   = '0;
               fail_d  = 3'b000;
`ifdef TRI_AND_TESTER_FIRST_FAIL_EN
               ff_valid_d = 1'b0;
               ff_pat_d   = 3'd0;
               ff_gate_d  = 2'd0;
`endif
            end
         end

         StSettle: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == SettleLast) begin
               state_d = StCheck;
            end
         end

         StCheck: begin
            fail_d = fail_q | mism;
            err_d  = err_sat;
`ifdef TRI_AND_TESTER_FIRST_FAIL_EN
            // Capture only the first mismatching check of the run.
            if (!ff_valid_q && (mism != 3'b000)) begin
               ff_valid_d = 1'b1;
               ff_pat_d   = p_q;
               ff_gate_d  = low_gate;
            end
`endif
            if (p_q == 3'd7) begin
               state_d = StDone;
            end else begin
               state_d = StSettle;
               p_d     = p_q + 3'd1;
               cnt_d   = 8'd0;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Status flags are registered. busy covers the run plus the DONE entry
   // cycle; done and pass rise one cycle after DONE is entered, so done lands
   // 8*(SETTLE_CYCLES+1)+1 cycles after the accepting edge.
   always_comb begin
      busy_d = (state_d == StSettle) || (state_d == StCheck) || (state_q == StCheck);
      done_d = (state_q == StDone) && !accept;
      pass_d = done_d && (err_q == '0);
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         p_q     <= 3'd0;
         cnt_q   <= 8'd0;
         err_q   <= '0;
         fail_q  <= 3'b000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

`ifdef TRI_AND_TESTER_FIRST_FAIL_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ff_valid_q <= 1'b0;
         ff_pat_q   <= 3'd0;
         ff_gate_q  <= 2'd0;
      end else begin
         ff_valid_q <= ff_valid_d;
         ff_pat_q   <= ff_pat_d;
         ff_gate_q  <= ff_gate_d;
      end
   end

   assign first_fail_valid = ff_valid_q;
   assign first_fail_pat   = ff_pat_q;
   assign first_fail_gate  = ff_gate_q;
`else
   // low_gate only feeds the first-fail capture.
   logic unused_low_gate;
   assign unused_low_gate = ^low_gate;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      abc_out = 9'd0;
      if ((state_q == StSettle) || (state_q == StCheck)) begin
         abc_out = {p_q, p_q, p_q};
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_gate = fail_q;

endmodule

// File: tb/tb_tri_and_gate_tester.sv
// -----------------------------------------------------------------------------
// tb_tri_and_gate_tester
//
// Self-checking bench for tri_and_gate_tester with default parameters. Gate
// faults (stuck-at-0 / stuck-at-1 masks) are emulated in the bench; expected
// results come from a per-run model that walks the eight patterns directly.
// -----------------------------------------------------------------------------
module tb_tri_and_gate_tester;

   localparam int unsigned S   = 2;
   localparam int unsigned EW  = 4;
   localparam int          RUN = 8 * (S + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [2:0]    y_in;
   logic [8:0]    abc_out;
   logic          busy;
   logic          done;
   logic          pass;
   logic [EW-1:0] err_count;
   logic [2:0]    fail_gate;
`ifdef TRI_AND_TESTER_FIRST_FAIL_EN
   logic          first_fail_valid;
   logic [2:0]    first_fail_pat;
   logic [1:0]    first_fail_gate;
`endif

   tri_and_gate_tester #(
      .SETTLE_CYCLES (S),
      .ERR_W         (EW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abc_out   (abc_out),
      .y_in      (y_in),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_gate (fail_gate)
`ifdef TRI_AND_TESTER_FIRST_FAIL_EN
      ,
      .first_fail_valid (first_fail_valid),
      .first_fail_pat   (first_fail_pat),
      .first_fail_gate  (first_fail_gate)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model outputs for the current cycle.
   logic          chk_en  = 1'b0;
   logic          chk_res = 1'b0;
   logic [8:0]    exp_abc;
   logic          exp_busy;
   logic          exp_done;
   logic          exp_pass;
   logic [EW-1:0] exp_err;
   logic [2:0]    exp_fail;
   logic          exp_ffv;
   logic [2:0]    exp_ffp;
   logic [1:0]    exp_ffg;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Output of faulty gate g when all three inputs equal pattern p.
   function automatic logic gate_y(input int p, input int g, input logic [2:0] sa0,
                                   input logic [2:0] sa1);
      return ((p == 7) && !sa0[g]) || sa1[g];
   endfunction

   // Whole-run expectation computed straight from the pattern walk.
   task automatic model_run(input logic [2:0] sa0, input logic [2:0] sa1, output int raw,
                            output logic [2:0] fm, output logic ffv, output logic [2:0] ffp,
                            output logic [1:0] ffg);
      raw = 0;
      fm  = 3'b000;
      ffv = 1'b0;
      ffp = 3'd0;
      ffg = 2'd0;
      for (int p = 0; p < 8; p++) begin
         for (int g = 0; g < 3; g++) begin
            if (gate_y(p, g, sa0, sa1) != (p == 7)) begin
               raw++;
               fm[g] = 1'b1;
               if (!ffv) begin
                  ffv = 1'b1;
                  ffp = 3'(p);
                  ffg = 2'(g + 1);
               end
            end
         end
      end
   endtask

   task automatic set_idle_model();
      exp_abc  = 9'd0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_pass = 1'b0;
      exp_err  = '0;
      exp_fail = 3'b000;
      exp_ffv  = 1'b0;
      exp_ffp  = 3'd0;
      exp_ffg  = 2'd0;
      chk_res  = 1'b1;
   endtask

   // The single per-cycle compare process.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("abc_out", 32'(abc_out), 32'(exp_abc));
         cmp("busy", 32'(busy), 32'(exp_busy));
         cmp("done", 32'(done), 32'(exp_done));
         cmp("pass", 32'(pass), 32'(exp_pass));
         if (chk_res) begin
            cmp("err_count", 32'(err_count), 32'(exp_err));
            cmp("fail_gate", 32'(fail_gate), 32'(exp_fail));
`ifdef TRI_AND_TESTER_FIRST_FAIL_EN
            cmp("first_fail_valid", 32'(first_fail_valid), 32'(exp_ffv));
            if (exp_ffv) begin
               cmp("first_fail_pat", 32'(first_fail_pat), 32'(exp_ffp));
               cmp("first_fail_gate", 32'(first_fail_gate), 32'(exp_ffg));
            end
`endif
         end
      end
   end

   // One run: start is raised now (#1 after an edge) and accepted on the next
   // edge. extra = phase at which a stray start is pulsed (-1 for none);
   // abort = phase during which rst is asserted (-1 for none).
   task automatic do_run(input logic [2:0] sa0, input logic [2:0] sa1, input int extra,
                         input int abort);
      int         raw;
      logic [2:0] fm;
      logic       ffv;
      logic [2:0] ffp;
      logic [1:0] ffg;
      model_run(sa0, sa1, raw, fm, ffv, ffp, ffg);
      start = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      chk_res = 1'b0;
      for (int k = 0; k <= RUN + 2; k++) begin
         if (k < RUN) begin
            int p;
            p        = k / (S + 1);
            exp_abc  = {3'(p), 3'(p), 3'(p)};
            exp_busy = 1'b1;
            exp_done = 1'b0;
            exp_pass = 1'b0;
            if ((k % (S + 1)) == S) begin
               for (int g = 0; g < 3; g++) y_in[g] = gate_y(p, g, sa0, sa1);
            end else begin
               y_in = 3'($urandom);
            end
         end else if (k == RUN) begin
            exp_abc  = 9'd0;
            exp_busy = 1'b1;
            exp_done = 1'b0;
            exp_pass = 1'b0;
            y_in     = 3'($urandom);
         end else begin
            exp_abc  = 9'd0;
            exp_busy = 1'b0;
            exp_done = 1'b1;
            exp_pass = (raw == 0);
            exp_err  = (raw > 15) ? 4'd15 : EW'(raw);
            exp_fail = fm;
            exp_ffv  = ffv;
            exp_ffp  = ffp;
            exp_ffg  = ffg;
            chk_res  = 1'b1;
            y_in     = 3'($urandom);
         end
         if ((sa0 == 3'b000) && (sa1 == 3'b000) && (k == 3)) cmp("abc_lit_p1", 32'(abc_out), 32'h049);
         if ((sa0 == 3'b000) && (sa1 == 3'b000) && (k == 21)) cmp("abc_lit_p7", 32'(abc_out), 32'h1FF);
         start = (k == extra);
         if (k == abort) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst   = 1'b0;
            start = 1'b0;
            set_idle_model();
            return;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      y_in  = 3'b000;
      set_idle_model();
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      // y_in is ignored while idle.
      repeat (3) begin
         y_in = 3'($urandom);
         @(posedge clk);
         #1;
      end

      // Ideal gates.
      do_run(3'b000, 3'b000, -1, -1);
      cmp("lit_ideal_err", 32'(err_count), 32'd0);
      cmp("lit_ideal_pass", 32'(pass), 32'd1);

      // Gate 2 stuck-at-1; restart straight from DONE.
      do_run(3'b000, 3'b010, -1, -1);
      cmp("lit_g2_err", 32'(err_count), 32'd7);
      cmp("lit_g2_fail", 32'(fail_gate), 32'b010);
      cmp("lit_g2_pass", 32'(pass), 32'd0);

      // All gates stuck-at-1: 21 raw mismatches saturate at 15.
      do_run(3'b000, 3'b111, -1, -1);
      cmp("lit_sat_err", 32'(err_count), 32'd15);
      cmp("lit_sat_fail", 32'(fail_gate), 32'b111);

      // Gates 1 and 3 stuck-at-0.
      do_run(3'b101, 3'b000, -1, -1);
      cmp("lit_sa0_err", 32'(err_count), 32'd2);
`ifdef TRI_AND_TESTER_FIRST_FAIL_EN
      cmp("lit_sa0_ffp", 32'(first_fail_pat), 32'd7);
      cmp("lit_sa0_ffg", 32'(first_fail_gate), 32'd1);
`endif

      // Reset during the check of p=3, then a full run.
      do_run(3'b010, 3'b000, -1, 11);
      cmp("lit_rst_abc", 32'(abc_out), 32'd0);
      do_run(3'b000, 3'b000, -1, -1);

      // Stray starts while busy are ignored, including the DONE entry cycle.
      do_run(3'b000, 3'b000, 5, -1);
      do_run(3'b001, 3'b100, RUN, -1);

      // Randomised fault masks and stray-start positions.
      for (int i = 0; i < 8; i++) begin
         do_run(3'($urandom), 3'($urandom), int'($urandom_range(0, RUN)) - 1, -1);
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
